pll_reset_sequencer: RTL and testbench

Drives the PLL `rst` input and consumes the PLL `locked` output, the controller end of the PLL wrapper interface. Runs on the PLL reference clock, synchronizes `locked`, and pulses the PLL reset on power-up, lock timeout and lock loss. Downstream logic receives a clean `sys_rst` only after lock has been continuously stable. Sits between the board reset and the SDRAM test logic.

---
 rtl/pll_reset_sequencer_if.sv | 21 ++
 rtl/pll_reset_sequencer.sv | 109 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Controller-side view of the PLL wrapper: PLL lock in, PLL reset and
// downstream reset/status out.
interface pll_reset_sequencer_if;
  logic       locked_in;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lost_count;

  modport master (
    input  locked_in,
    output pll_rst, sys_rst, ready, fail, retry_count, lost_count
  );

  modport slave (
    output locked_in,
    input  pll_rst, sys_rst, ready, fail, retry_count, lost_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a stable lock and
// only then releases the downstream reset; retries on timeout, restarts on loss.
module pll_reset_sequencer #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 7
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned CNT_MAX_A = (RST_PULSE_CYCLES > STABLE_CYCLES) ?
                                      RST_PULSE_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ?
                                      CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAILED
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_cnt;
  logic          r_s1;
  logic          r_s2;
  logic [3:0]    r_retry;
  logic [7:0]    r_lost;
  logic          r_pll_rst;
  logic          r_sys_rst;
  logic          r_ready;
  logic          r_fail;
  logic          w_retry_inc;
  logic          w_lost_inc;

  always_comb begin
    w_state_n   = r_state;
    w_retry_inc = 1'b0;
    w_lost_inc  = 1'b0;
    case (r_state)
      ST_RESET_PLL:
        if (r_cnt == CW'(RST_PULSE_CYCLES - 1)) w_state_n = ST_WAIT_LOCK;
      ST_WAIT_LOCK:
        // a lock seen on the timeout cycle still counts as a lock
        if (r_s2) begin
          w_state_n = ST_STABILIZE;
        end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (r_retry == 4'(MAX_RETRIES)) begin
            w_state_n = ST_FAILED;
          end else begin
            w_state_n   = ST_RESET_PLL;
            w_retry_inc = 1'b1;
          end
        end
      ST_STABILIZE:
        if (!r_s2)                                    w_state_n = ST_WAIT_LOCK;
        else if (r_cnt == CW'(STABLE_CYCLES - 1))     w_state_n = ST_RUN;
      ST_RUN:
        if (!r_s2) begin
          w_state_n  = ST_RESET_PLL;
          w_lost_inc = 1'b1;
        end
      ST_FAILED: w_state_n = ST_FAILED;
      default:   w_state_n = ST_RESET_PLL;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= ST_RESET_PLL;
      r_cnt     <= '0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_retry   <= 4'd0;
      r_lost    <= 8'd0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_s1      <= bus.locked_in;
      r_s2      <= r_s1;
      r_state   <= w_state_n;
      r_cnt     <= (w_state_n != r_state) ? '0 : r_cnt + 1'b1;
      if (w_state_n == ST_RUN)  r_retry <= 4'd0;
      else if (w_retry_inc)     r_retry <= r_retry + 4'd1;
      if (w_lost_inc && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
      r_pll_rst <= (w_state_n == ST_RESET_PLL);
      r_sys_rst <= (w_state_n != ST_RUN);
      r_ready   <= (w_state_n == ST_RUN);
      r_fail    <= (w_state_n == ST_FAILED);
    end
  end

  assign bus.pll_rst     = r_pll_rst;
  assign bus.sys_rst     = r_sys_rst;
  assign bus.ready       = r_ready;
  assign bus.fail        = r_fail;
  assign bus.retry_count = r_retry;
  assign bus.lost_count  = r_lost;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: phase/duration model checked every cycle,
// plus directed scenarios with hand-computed edge distances.
module tb_pll_reset_sequencer;
  localparam int RP = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 2;

  localparam int P_PULSE = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAIL = 4;
  localparam int S_PLL = 0, S_SYS = 1, S_RDY = 2, S_FAIL = 3, S_RETRY = 4, S_LOST = 5;

  logic refclk = 1'b0;
  logic rst;
  always #5 refclk = ~refclk;

  pll_reset_sequencer_if u_if ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO),
    .STABLE_CYCLES(SC), .MAX_RETRIES(MR)
  ) u_dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (u_if.master)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model: current phase, edge at which it was entered, synchronizer history
  bit   m_on = 1'b0;
  int   ph, ent, m_retry, m_lost;
  logic m_s1, m_s2;

  always @(posedge refclk) begin
    logic r_i, l_i;
    logic [15:0] exp_v, act_v;
    r_i = rst;
    l_i = u_if.locked_in;
    cyc++;
    if (r_i) begin
      ph = P_PULSE; ent = cyc; m_retry = 0; m_lost = 0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_on = 1'b1;
    end else if (m_on) begin
      int age, nph;
      age = cyc - ent;
      nph = ph;
      case (ph)
        P_PULSE: if (age == RP) nph = P_WAIT;
        P_WAIT: begin
          if (m_s2) nph = P_STAB;
          else if (age == TO) begin
            if (m_retry == MR) nph = P_FAIL;
            else begin m_retry++; nph = P_PULSE; end
          end
        end
        P_STAB: begin
          if (!m_s2) nph = P_WAIT;
          else if (age == SC) nph = P_RUN;
        end
        P_RUN: if (!m_s2) begin nph = P_PULSE; if (m_lost < 255) m_lost++; end
        default: ;
      endcase
      if (nph != ph) ent = cyc;
      ph = nph;
      if (ph == P_RUN) m_retry = 0;
      m_s2 = m_s1;
      m_s1 = l_i;
    end
    if (m_on) begin
      #1;
      exp_v = {ph == P_PULSE, ph != P_RUN, ph == P_RUN, ph == P_FAIL,
               4'(m_retry), 8'(m_lost)};
      act_v = {u_if.pll_rst, u_if.sys_rst, u_if.ready, u_if.fail,
               u_if.retry_count, u_if.lost_count};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle edge %0d: dut pll/sys/rdy/fail/retry/lost=%b/%b/%b/%b/%0d/%0d required %b/%b/%b/%b/%0d/%0d",
                 cyc, act_v[15], act_v[14], act_v[13], act_v[12], act_v[11:8], act_v[7:0],
                 exp_v[15], exp_v[14], exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
      end
    end
  end

  function automatic int sig(input int s);
    case (s)
      S_PLL:   return int'(u_if.pll_rst);
      S_SYS:   return int'(u_if.sys_rst);
      S_RDY:   return int'(u_if.ready);
      S_FAIL:  return int'(u_if.fail);
      S_RETRY: return int'(u_if.retry_count);
      default: return int'(u_if.lost_count);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_for(input int s, input int val, input int bound, input string nm);
    int k;
    k = 0;
    while (sig(s) != val && k < bound) begin
      @(negedge refclk);
      k++;
    end
    if (sig(s) != val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout, got %0d required %0d", nm, sig(s), val);
    end
  endtask

  task automatic pulse_len(input string nm);
    int n;
    n = 0;
    while (sig(S_PLL) == 1 && n < 20) begin
      @(negedge refclk);
      n++;
    end
    chk(nm, n, RP);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll"},   sig(S_PLL),   1);
    chk({tag, "_sys"},   sig(S_SYS),   1);
    chk({tag, "_rdy"},   sig(S_RDY),   0);
    chk({tag, "_fail"},  sig(S_FAIL),  0);
    chk({tag, "_retry"}, sig(S_RETRY), 0);
    chk({tag, "_lost"},  sig(S_LOST),  0);
  endtask

  initial begin
    int t, t2, f0, f1, f2, n;
    rst = 1'b1;
    u_if.locked_in = 1'b0;
    repeat (3) @(negedge refclk);
    chk_reset_vals("reset");

    // normal bring-up
    rst = 1'b0;
    pulse_len("bringup_pulse_len");
    repeat (4) @(negedge refclk);
    u_if.locked_in = 1'b1;
    t = cyc + 1;
    wait_for(S_SYS, 0, 40, "bringup_release");
    chk("bringup_release_edges", cyc - t, 10);
    chk("bringup_ready", sig(S_RDY), 1);
    chk("bringup_retry", sig(S_RETRY), 0);

    // loss in RUN
    u_if.locked_in = 1'b0;
    @(negedge refclk); chk("loss_rdy_e0", sig(S_RDY), 1);
    @(negedge refclk); chk("loss_rdy_e1", sig(S_RDY), 1);
    @(negedge refclk);
    chk("loss_rdy_e2", sig(S_RDY), 0);
    chk("loss_sys_e2", sig(S_SYS), 1);
    chk("loss_lost_e2", sig(S_LOST), 1);
    pulse_len("loss_pulse_len");
    u_if.locked_in = 1'b1;
    wait_for(S_RDY, 1, 60, "loss_relock");

    // lost_count saturation
    for (int i = 0; i < 300; i++) begin
      u_if.locked_in = 1'b0;
      repeat (3) @(negedge refclk);
      u_if.locked_in = 1'b1;
      wait_for(S_RDY, 1, 60, "sat_relock");
      if (i == 252) chk("lost_pre_sat", sig(S_LOST), 254);
    end
    chk("lost_saturated", sig(S_LOST), 255);

    // timeout and fail
    u_if.locked_in = 1'b0;
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    wait_for(S_PLL, 0, 20, "to_fall0");  f0 = cyc;
    wait_for(S_PLL, 1, 40, "to_rise1");
    chk("to_retry1", sig(S_RETRY), 1);
    wait_for(S_PLL, 0, 20, "to_fall1");  f1 = cyc;
    chk("to_period1", f1 - f0, 24);
    wait_for(S_PLL, 1, 40, "to_rise2");
    chk("to_retry2", sig(S_RETRY), 2);
    wait_for(S_PLL, 0, 20, "to_fall2");  f2 = cyc;
    chk("to_period2", f2 - f1, 24);
    wait_for(S_FAIL, 1, 40, "to_fail");
    chk("to_fail_after_last", cyc - f2, 20);
    chk("to_fail_total", cyc - f0, 68);
    n = 0;
    repeat (200) begin
      @(negedge refclk);
      if (sig(S_FAIL) == 1 && sig(S_PLL) == 0 && sig(S_SYS) == 1 && sig(S_RDY) == 0) n++;
    end
    chk("fail_held_200", n, 200);
    rst = 1'b1;
    @(negedge refclk);
    chk_reset_vals("fail_reset");

    // glitch in STABILIZE with one retry already spent
    rst = 1'b0;
    wait_for(S_RETRY, 1, 60, "gl_retry1");
    wait_for(S_PLL, 0, 20, "gl_fall");
    u_if.locked_in = 1'b1;
    repeat (7) @(negedge refclk);
    u_if.locked_in = 1'b0;
    @(negedge refclk);
    u_if.locked_in = 1'b1;
    t2 = cyc + 1;
    repeat (2) @(negedge refclk);
    chk("gl_sys_held", sig(S_SYS), 1);
    chk("gl_retry_kept", sig(S_RETRY), 1);
    @(negedge refclk);
    chk("gl_sys_held_late", sig(S_SYS), 1);
    wait_for(S_SYS, 0, 40, "gl_release");
    chk("gl_release_edges", cyc - t2, 10);
    chk("gl_retry_cleared", sig(S_RETRY), 0);

    // reset mid-operation at WAIT_LOCK count 10, retry_count 1
    u_if.locked_in = 1'b0;
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
    wait_for(S_RETRY, 1, 60, "mid_retry1");
    wait_for(S_PLL, 0, 20, "mid_fall");
    repeat (10) @(negedge refclk);
    chk("mid_pre_retry", sig(S_RETRY), 1);
    rst = 1'b1;
    @(negedge refclk);
    chk_reset_vals("mid_reset");
    rst = 1'b0;
    pulse_len("mid_restart_pulse");
    repeat (5) @(negedge refclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
